// File: rtl/encoder_pkg.sv
// Shared widths, index type and FSM state encoding for the registered 8-to-3 encoder.
package encoder_pkg;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] idx_t;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

endpackage

// File: rtl/encoder_prio_find_8.sv
// Combinational downward wrapping search: first set bit at start, start-1, ..., wrapping 0 -> 7.
module prio_find_8
    import encoder_pkg::*;
(
    input  logic [WIDTH-1:0] vec_i,
    input  idx_t             start_i,
    output logic             found_o,
    output idx_t             idx_o
);

    idx_t cand_s;

    // Scan WIDTH positions downward from the start pointer; the first hit wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = 3'd0;
        cand_s  = 3'd0;
        for (int i = 0; i < WIDTH; i++) begin
            cand_s = start_i - IDX_W'(i);
            if (!found_o && vec_i[cand_s]) begin
                found_o = 1'b1;
                idx_o   = cand_s;
            end else begin
                found_o = found_o;
            end
        end
    end

endmodule

// File: rtl/encoder_8x3_seq.sv
// Registered 8-to-3 encoder with pending capture and valid/ack handshake.
// Define ENCODER_RR_EN for rotating priority; otherwise fixed priority (7 highest).
module encoder_8x3_seq
    import encoder_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    input  logic             ack,
    output logic [IDX_W-1:0] out,
    output logic             valid,
    output logic [WIDTH-1:0] pending
);

    state_e           state_q, state_d;
    idx_t             out_q, out_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] pending_q, pending_d;
    idx_t             start_s;
    logic             found_s;
    idx_t             idx_s;

`ifdef ENCODER_RR_EN
    idx_t ptr_q, ptr_d;
    assign start_s = ptr_q;
`else
    assign start_s = 3'd7;
`endif

    prio_find_8 u_find (
        .vec_i   (pending_q),
        .start_i (start_s),
        .found_o (found_s),
        .idx_o   (idx_s)
    );

    // Next-state: presentation from registered pending, retirement on ack, then capture.
    always_comb begin
        state_d   = state_q;
        out_d     = out_q;
        valid_d   = valid_q;
        pending_d = pending_q;
`ifdef ENCODER_RR_EN
        ptr_d     = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (en && found_s) begin
                    out_d   = idx_s;
                    valid_d = 1'b1;
                    state_d = PRESENT;
                end else begin
                    valid_d = 1'b0;
                end
            end
            PRESENT: begin
                if (ack) begin
                    pending_d[out_q] = 1'b0;
                    valid_d          = 1'b0;
                    state_d          = IDLE;
`ifdef ENCODER_RR_EN
                    ptr_d            = out_q - 3'd1;
`endif
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
        // Capture after retirement so a same-cycle re-request keeps the bit set.
        if (en) begin
            pending_d = pending_d | in;
        end else begin
            pending_d = pending_d;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            out_q     <= 3'd0;
            valid_q   <= 1'b0;
            pending_q <= 8'd0;
        end else begin
            state_q   <= state_d;
            out_q     <= out_d;
            valid_q   <= valid_d;
            pending_q <= pending_d;
        end
    end

`ifdef ENCODER_RR_EN
    // Rotating-priority pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 3'd7;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`endif

    assign out     = out_q;
    assign valid   = valid_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_encoder_8x3_seq.sv
// Directed self-checking bench for encoder_8x3_seq (expectations follow ENCODER_RR_EN).
module tb_encoder_8x3_seq;
    import encoder_pkg::*;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [WIDTH-1:0] in;
    logic             ack;
    logic [IDX_W-1:0] out;
    logic             valid;
    logic [WIDTH-1:0] pending;

    int checks;
    int failures;

    encoder_8x3_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .in      (in),
        .ack     (ack),
        .out     (out),
        .valid   (valid),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; in = 8'h00; ack = 1'b0;
        #12;
        checks++;
        if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++;
        if (out !== 3'd0) begin failures++; $display("FAIL reset_out got=%0d exp=0", out); end
        checks++;
        if (pending !== 8'h00) begin failures++; $display("FAIL reset_pending got=%h exp=00", pending); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        en = 1'b1; in = 8'b0010_0100;
        tick();
        in = 8'h00;
        tick();
        checks++;
        if (valid !== 1'b1 || out !== 3'd5) begin
            failures++; $display("FAIL basic_first valid=%b out=%0d exp valid=1 out=5", valid, out);
        end
        checks++;
        if (pending !== 8'h24) begin failures++; $display("FAIL basic_pending got=%h exp=24", pending); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        checks++;
        if (valid !== 1'b0 || pending !== 8'h04) begin
            failures++; $display("FAIL basic_bubble valid=%b pending=%h exp valid=0 pending=04", valid, pending);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || out !== 3'd2) begin
            failures++; $display("FAIL basic_second valid=%b out=%0d exp valid=1 out=2", valid, out);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            failures++; $display("FAIL basic_drained valid=%b pending=%h exp valid=0 pending=00", valid, pending);
        end
    endtask

    task automatic test_en_low();
        en = 1'b0; in = 8'hFF;
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (pending !== 8'h00 || valid !== 1'b0) begin
                failures++; $display("FAIL en_low_c%0d pending=%h valid=%b exp pending=00 valid=0", c, pending, valid);
            end
        end
        in = 8'h00; en = 1'b1;
        tick();
    endtask

    task automatic test_ack_rerequest();
        in = 8'h08;
        tick();
        in = 8'h00;
        tick();
        checks++;
        if (valid !== 1'b1 || out !== 3'd3) begin
            failures++; $display("FAIL rereq_present valid=%b out=%0d exp valid=1 out=3", valid, out);
        end
        ack = 1'b1; in = 8'h08;
        tick();
        ack = 1'b0; in = 8'h00;
        checks++;
        if (valid !== 1'b0 || pending !== 8'h08) begin
            failures++; $display("FAIL rereq_kept valid=%b pending=%h exp valid=0 pending=08", valid, pending);
        end
        tick();
        checks++;
        if (valid !== 1'b1 || out !== 3'd3) begin
            failures++; $display("FAIL rereq_again valid=%b out=%0d exp valid=1 out=3", valid, out);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
    endtask

    task automatic test_no_preempt();
        in = 8'h40;
        tick();
        in = 8'h00;
        tick();
        for (int c = 0; c < 10; c++) begin
            in = (c == 3) ? 8'h80 : 8'h00;
            checks++;
            if (valid !== 1'b1 || out !== 3'd6) begin
                failures++; $display("FAIL hold_c%0d valid=%b out=%0d exp valid=1 out=6", c, valid, out);
            end
            tick();
        end
        in = 8'h00; ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
        checks++;
        if (valid !== 1'b1 || out !== 3'd7) begin
            failures++; $display("FAIL after_hold valid=%b out=%0d exp valid=1 out=7", valid, out);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        in = 8'h02;
        tick();
        in = 8'h00;
        tick();
        checks++;
        if (valid !== 1'b1) begin failures++; $display("FAIL arst_pre valid=%b exp=1", valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (valid !== 1'b0 || out !== 3'd0 || pending !== 8'h00) begin
            failures++; $display("FAIL arst_now valid=%b out=%0d pending=%h exp 0/0/00", valid, out, pending);
        end
        #3;
        rst_n = 1'b1;
        tick();
        tick();
        checks++;
        if (valid !== 1'b0 || pending !== 8'h00) begin
            failures++; $display("FAIL arst_idle valid=%b pending=%h exp valid=0 pending=00", valid, pending);
        end
    endtask

    task automatic test_back_to_back();
        logic [IDX_W-1:0] exp_idx;
        en = 1'b1; in = 8'hFF;
        tick();
        in = 8'h00;
        for (int g = 0; g < 8; g++) begin
            int n;
            n = 0;
            while (valid !== 1'b1 && n < 4) begin
                tick();
                n++;
            end
            exp_idx = 3'(7 - g);
            checks++;
            if (valid !== 1'b1 || out !== exp_idx) begin
                failures++; $display("FAIL grant_%0d valid=%b out=%0d exp valid=1 out=%0d", g, valid, out, exp_idx);
            end
            ack = 1'b1;
            tick();
            ack = 1'b0;
        end
        tick();
        in = 8'h10;
        tick();
        in = 8'h00;
        tick();
        checks++;
        if (valid !== 1'b1 || out !== 3'd4) begin
            failures++; $display("FAIL grant4 valid=%b out=%0d exp valid=1 out=4", valid, out);
        end
        ack = 1'b1;
        tick();
        ack = 1'b0; in = 8'b1000_0100;
        tick();
        in = 8'h00;
        tick();
`ifdef ENCODER_RR_EN
        exp_idx = 3'd2;
`else
        exp_idx = 3'd7;
`endif
        checks++;
        if (valid !== 1'b1 || out !== exp_idx) begin
            failures++; $display("FAIL followup valid=%b out=%0d exp valid=1 out=%0d", valid, out, exp_idx);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_en_low();
        test_ack_rerequest();
        test_no_preempt();
        test_async_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
